// File: rtl/gpu_pkg.sv
// Shared core-level types: the lifecycle state seen by scheduler, fetcher, LSU and PC units.
package gpu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        REQUEST = 3'd3,
        WAIT    = 3'd4,
        EXECUTE = 3'd5,
        UPDATE  = 3'd6,
        DONE    = 3'd7
    } core_state_t;

endpackage

// File: rtl/pc_select.sv
// Picks the next_pc of the lowest-indexed active thread and flags any active
// thread that disagrees with it.
module pc_select #(
    parameter int THREADS    = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic [THREADS-1:0]            i_mask,
    input  logic [THREADS*ADDR_WIDTH-1:0] i_next_pc,
    output logic [ADDR_WIDTH-1:0]         o_sel_pc,
    output logic                          o_mismatch
);

    logic [ADDR_WIDTH-1:0] w_sel;
    logic                  w_found;
    logic                  w_mis;

    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        for (int i = 0; i < THREADS; i++) begin
            if (i_mask[i] && !w_found) begin
                w_sel   = i_next_pc[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_found = 1'b1;
            end
        end
        w_mis = 1'b0;
        for (int i = 0; i < THREADS; i++) begin
            if (i_mask[i] && (i_next_pc[i*ADDR_WIDTH +: ADDR_WIDTH] != w_sel))
                w_mis = 1'b1;
        end
    end

    assign o_sel_pc   = w_sel;
    assign o_mismatch = w_mis;

endmodule

// File: rtl/core_scheduler.sv
// Per-core lifecycle sequencer: steps core_state, owns current_pc, counts retired
// instructions and reports block completion.
module core_scheduler
    import gpu_pkg::*;
#(
    parameter int                    THREADS     = 4,
    parameter int                    ADDR_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] START_PC    = '0,
    parameter int                    COUNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [THREADS-1:0]            thread_enable,
    input  logic                          fetch_valid,
    input  logic                          decoded_ret,
    input  logic [THREADS-1:0]            lsu_busy,
    input  logic [THREADS*ADDR_WIDTH-1:0] next_pc,
    output core_state_t                   core_state,
    output logic [ADDR_WIDTH-1:0]         current_pc,
    output logic                          fetch_req,
    output logic                          done,
    output logic                          diverged,
    output logic [COUNT_WIDTH-1:0]        inst_count
);

    core_state_t            r_state, w_next;
    logic [THREADS-1:0]     r_mask;
    logic [ADDR_WIDTH-1:0]  r_pc;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_div;
    logic [ADDR_WIDTH-1:0]  w_sel_pc;
    logic                   w_mismatch;

    pc_select #(
        .THREADS    (THREADS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pc_select (
        .i_mask     (r_mask),
        .i_next_pc  (next_pc),
        .o_sel_pc   (w_sel_pc),
        .o_mismatch (w_mismatch)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = (|thread_enable) ? FETCH : DONE;
            FETCH:   if (fetch_valid) w_next = DECODE;
            DECODE:  w_next = REQUEST;
            REQUEST: w_next = WAIT;
            // Only threads of the launched block can hold the core in WAIT
            WAIT:    if ((lsu_busy & r_mask) == '0) w_next = EXECUTE;
            EXECUTE: w_next = UPDATE;
            UPDATE:  w_next = decoded_ret ? DONE : FETCH;
            DONE:    if (!start) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask  <= '0;
            r_pc    <= '0;
            r_count <= '0;
            r_div   <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_count <= '0;
            r_div   <= 1'b0;
            if (|thread_enable) begin
                r_mask <= thread_enable;
                r_pc   <= START_PC;
            end
        end else if (r_state == UPDATE) begin
            // RET retires too, but the PC stays on the RET instruction
            if (!decoded_ret)      r_pc    <= w_sel_pc;
            if (w_mismatch)        r_div   <= 1'b1;
            if (r_count != '1)     r_count <= r_count + 1'b1;
        end
    end

    assign core_state = r_state;
    assign current_pc = r_pc;
    assign fetch_req  = (r_state == FETCH);
    assign done       = (r_state == DONE);
    assign diverged   = r_div;
    assign inst_count = r_count;

endmodule

// File: tb/tb_core_scheduler.sv
// Randomized program runs against a per-instruction reference model; expected
// fetch/done/idle events are queued up front and checked by an independent monitor.
module tb_core_scheduler;
    import gpu_pkg::*;

    localparam int         T   = 4;
    localparam int         AW  = 8;
    localparam int         CW  = 3;
    localparam logic [7:0] SPC = 8'h20;
    localparam int         MAXC = 512;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [T-1:0]      thread_enable = '0;
    logic              fetch_valid = 1'b0;
    logic              decoded_ret = 1'b0;
    logic [T-1:0]      lsu_busy = '0;
    logic [T*AW-1:0]   next_pc = '0;
    core_state_t       core_state;
    logic [AW-1:0]     current_pc;
    logic              fetch_req, done, diverged;
    logic [CW-1:0]     inst_count;

    core_scheduler #(.THREADS(T), .ADDR_WIDTH(AW), .START_PC(SPC), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .thread_enable(thread_enable),
        .fetch_valid(fetch_valid), .decoded_ret(decoded_ret), .lsu_busy(lsu_busy),
        .next_pc(next_pc), .core_state(core_state), .current_pc(current_pc),
        .fetch_req(fetch_req), .done(done), .diverged(diverged), .inst_count(inst_count)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;   // 0 fetch entered, 1 done entered, 2 back to idle
        longint      cyc;
        logic [7:0]  pc;
        int          cnt;
        bit          div;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   errs    = 0;

    // reference model state, persists across runs
    logic [7:0] m_pc  = 8'h00;
    int         m_cnt = 0;
    bit         m_div = 0;

    bit              a_fv  [MAXC];
    logic [T-1:0]    a_busy[MAXC];
    bit              a_upd [MAXC];
    logic [T*AW-1:0] a_npc [MAXC];

    task automatic push(input int kind, input longint c);
        exp_t e;
        e.kind = kind; e.cyc = c; e.pc = m_pc; e.cnt = m_cnt; e.div = m_div;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: pops one expected event per observed DUT event
    bit p_f = 0, p_d = 0;
    task automatic check_ev(input int kind);
        exp_t e;
        bit   ok;
        vectors++;
        if (q.size() == 0) begin
            errs++;
            $display("FAIL unexpected_event kind=%0d at cycle %0d", kind, cyc);
            return;
        end
        e  = q.pop_front();
        ok = (e.kind == kind) && (e.cyc == cyc) && (current_pc == e.pc) &&
             (int'(inst_count) == e.cnt) && (diverged == e.div);
        if (kind == 2 && core_state != IDLE) ok = 0;
        if (!ok) begin
            errs++;
            $display("FAIL event: got kind=%0d cyc=%0d pc=%0h cnt=%0d div=%0b state=%0d expected kind=%0d cyc=%0d pc=%0h cnt=%0d div=%0b",
                     kind, cyc, current_pc, inst_count, diverged, core_state,
                     e.kind, e.cyc, e.pc, e.cnt, e.div);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (fetch_req && !p_f) check_ev(0);
            if (done && !p_d)      check_ev(1);
            if (!done && p_d)      check_ev(2);
        end
        p_f <= fetch_req;
        p_d <= done;
    end

    // One block from launch to return-to-IDLE. Called at a negedge in IDLE; that cycle is cycle 0.
    task automatic launch_run(input logic [T-1:0] mask, input int n, input bit do_reset, input bit fixed);
        longint     c0;
        int         s, fd, ws, upd, mode, d_cyc, h, last, retfrom, g;
        logic [7:0] np[T];
        logic [7:0] sel;
        logic [T-1:0] b;
        bit         mism, found;
        for (int i = 0; i < MAXC; i++) begin
            a_fv[i] = 0; a_busy[i] = '0; a_upd[i] = 0; a_npc[i] = '0;
        end
        c0 = cyc;
        m_cnt = 0; m_div = 0;
        retfrom = MAXC;
        if (mask == '0) begin
            d_cyc = 1;
            push(1, c0 + 1);
        end else begin
            m_pc = SPC;
            s = 1;
            for (int k = 0; k < n; k++) begin
                fd = fixed ? 0 : $urandom_range(0, 2);
                ws = fixed ? 0 : $urandom_range(0, 3);
                if (do_reset) begin fd = 0; ws = 4; end
                if (!do_reset || k == 0) push(0, c0 + s);
                a_fv[s + fd] = 1;
                for (int j = 0; j < ws; j++) begin
                    do b = T'($urandom) & mask; while (b == '0);
                    a_busy[s + fd + 3 + j] = b;
                end
                upd = s + fd + ws + 5;
                a_upd[upd] = 1;
                mode = fixed ? 0 : $urandom_range(0, 2);
                sel = 8'($urandom);
                for (int t = 0; t < T; t++) begin
                    if (mode == 0)      np[t] = m_pc + 8'd1;
                    else if (mode == 1) np[t] = sel;
                    else                np[t] = 8'($urandom_range(0, 3));
                    a_npc[upd][t*AW +: AW] = np[t];
                end
                found = 0; sel = 8'h00;
                for (int t = 0; t < T; t++)
                    if (mask[t] && !found) begin sel = np[t]; found = 1; end
                mism = 0;
                for (int t = 0; t < T; t++)
                    if (mask[t] && np[t] != sel) mism = 1;
                if (k == n - 1) retfrom = upd - 1;
                m_div = m_div | mism;
                m_cnt = (m_cnt + 1 > 7) ? 7 : m_cnt + 1;
                if (k != n - 1) m_pc = sel;
                s = upd + 1;
            end
            d_cyc = s;
            if (!do_reset) push(1, c0 + d_cyc);
        end
        h = $urandom_range(0, 2);
        if (!do_reset) push(2, c0 + d_cyc + h + 1);
        last = do_reset ? 6 : d_cyc + h;
        for (int r = 0; r <= last; r++) begin
            if (r > 0) @(negedge clk);
            if (r == 0)              start = 1'b1;
            else if (r < d_cyc)      start = 1'($urandom);
            else                     start = (r < d_cyc + h);
            thread_enable = (r == 0) ? mask : T'($urandom);
            fetch_valid   = a_fv[r];
            lsu_busy      = a_busy[r] | (T'($urandom) & ~mask);
            if (r >= retfrom)  decoded_ret = 1'b1;
            else if (a_upd[r]) decoded_ret = 1'b0;
            else               decoded_ret = 1'($urandom);
            next_pc = a_upd[r] ? a_npc[r] : (T*AW)'($urandom);
            if (do_reset && r == 6) begin
                rst_n = 1'b0;
                start = 1'b0;
                #1;
                chk("rst_mid_state", core_state, IDLE);
                chk("rst_mid_pc", current_pc, 0);
                chk("rst_mid_fetch_req", fetch_req, 0);
                chk("rst_mid_done", done, 0);
                chk("rst_mid_diverged", diverged, 0);
                chk("rst_mid_count", inst_count, 0);
            end
        end
        @(negedge clk);
        start = 1'b0; fetch_valid = 1'b0; lsu_busy = '0;
        if (do_reset) begin
            rst_n = 1'b1;
            m_pc = 8'h00; m_cnt = 0; m_div = 0;
        end
        g = $urandom_range(0, 2);
        repeat (g) begin
            thread_enable = T'($urandom);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [T-1:0] mk;
        repeat (2) @(negedge clk);
        chk("reset_state", core_state, IDLE);
        chk("reset_pc", current_pc, 0);
        chk("reset_fetch_req", fetch_req, 0);
        chk("reset_done", done, 0);
        chk("reset_diverged", diverged, 0);
        chk("reset_count", inst_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        launch_run(4'b1111, 4, 0, 1);   // straight-line, minimum timing
        launch_run(4'b0000, 0, 0, 0);   // empty launch
        launch_run(4'b0110, 3, 0, 0);
        launch_run(4'b0011, 5, 0, 0);
        for (int i = 0; i < 24; i++) begin
            mk = ($urandom_range(0, 7) == 0) ? 4'b0000 : T'($urandom);
            launch_run(mk, $urandom_range(1, 10), 0, 0);
        end
        launch_run(4'b1011, 1, 1, 0);   // reset asserted in WAIT
        for (int i = 0; i < 6; i++) begin
            do mk = T'($urandom); while (mk == '0);
            launch_run(mk, $urandom_range(1, 10), 0, 0);
        end

        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
